// File: rtl/scalar_write_back_unit_if.sv
// Handshake bundle between the execute/memory producers, the
// write-back unit and the scalar register file write port.
interface scalar_write_back_unit_if #(
    parameter int DATA_LEN       = 32,
    parameter int SCALAR_REG_LEN = 64
);
    logic                      rdy_in;
    logic                      alu_valid;
    logic                      alu_ready;
    logic [4:0]                alu_rd;
    logic [SCALAR_REG_LEN-1:0] alu_data;
    logic                      mem_valid;
    logic                      mem_ready;
    logic [4:0]                mem_rd;
    logic [DATA_LEN-1:0]       mem_data;
    logic [1:0]                mem_size;
    logic                      mem_unsigned;
    logic [1:0]                rf_signal;
    logic [4:0]                rf_rd;
    logic [SCALAR_REG_LEN-1:0] rf_data;
    logic                      write_back_enabled;
    logic [1:0]                rf_status;
    logic                      wb_busy;
    logic                      wb_done;

    modport slave (
        input  rdy_in, alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data, mem_size, mem_unsigned,
        input  rf_status,
        output alu_ready, mem_ready,
        output rf_signal, rf_rd, rf_data, write_back_enabled,
        output wb_busy, wb_done
    );

    modport master (
        output rdy_in, alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data, mem_size, mem_unsigned,
        output rf_status,
        input  alu_ready, mem_ready,
        input  rf_signal, rf_rd, rf_data, write_back_enabled,
        input  wb_busy, wb_done
    );
endinterface

// File: rtl/scalar_write_back_unit.sv
// Scalar write-back stage: buffers ALU and load results in an
// in-order FIFO and drains them one at a time into the register file.
module scalar_write_back_unit #(
    parameter int DATA_LEN       = 32,
    parameter int SCALAR_REG_LEN = 64,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    scalar_write_back_unit_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [1:0] SCALAR_RF_WRITE = 2'b01;
    localparam logic [1:0] RF_FINISHED     = 2'b01;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    logic [4:0]                rd_mem   [FIFO_DEPTH];
    logic [SCALAR_REG_LEN-1:0] data_mem [FIFO_DEPTH];

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rptr_nx, alu_slot;
    logic [CW-1:0] count_q, count_d, free;
    logic          mem_fire, alu_fire, mem_push, alu_push, pop;
    logic [SCALAR_REG_LEN-1:0] mem_ext;

    state_t                    state_q;
    logic                      wbe_q;
    logic [1:0]                sig_q;
    logic [4:0]                rd_q;
    logic [SCALAR_REG_LEN-1:0] data_q;
    logic                      done_q;

    function automatic logic [SCALAR_REG_LEN-1:0] extend(
        input logic [DATA_LEN-1:0] raw,
        input logic [1:0]          size,
        input logic                uns
    );
        logic [SCALAR_REG_LEN-1:0] r;
        logic                      s;
        case (size)
            2'b00: begin
                s = raw[7] & ~uns;
                r = {{(SCALAR_REG_LEN-8){s}}, raw[7:0]};
            end
            2'b01: begin
                s = raw[15] & ~uns;
                r = {{(SCALAR_REG_LEN-16){s}}, raw[15:0]};
            end
            default: begin
                s = raw[DATA_LEN-1] & ~uns;
                r = {{(SCALAR_REG_LEN-DATA_LEN){s}}, raw};
            end
        endcase
        return r;
    endfunction

    // Accept logic: loads need one slot, ALU needs a second one when a load
    // competes in the same cycle. Nothing is accepted while in reset.
    always_comb begin
        free          = DEPTH_C - count_q;
        bus.mem_ready = bus.rdy_in & ~rst & (free != '0);
        bus.alu_ready = bus.rdy_in & ~rst &
                        ((free >= CW'(2)) | ((free != '0) & ~bus.mem_valid));
        mem_fire = bus.mem_valid & bus.mem_ready;
        alu_fire = bus.alu_valid & bus.alu_ready;
        mem_push = mem_fire & (bus.mem_rd != 5'd0);
        alu_push = alu_fire & (bus.alu_rd != 5'd0);
        pop      = bus.rdy_in & (state_q == WAIT) &
                   (bus.rf_status == RF_FINISHED);
        mem_ext  = extend(bus.mem_data, bus.mem_size, bus.mem_unsigned);
        alu_slot = wptr_q + PW'(mem_push);
        wptr_d   = alu_slot + PW'(alu_push);
        rptr_nx  = rptr_q + PW'(1);
        rptr_d   = pop ? rptr_nx : rptr_q;
        count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end

    // Result storage; the load lands first so it retires before the ALU result.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            rd_mem[wptr_q]   <= bus.mem_rd;
            data_mem[wptr_q] <= mem_ext;
        end
        if (alu_push) begin
            rd_mem[alu_slot]   <= bus.alu_rd;
            data_mem[alu_slot] <= bus.alu_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Drain FSM with registered register-file outputs; frozen when rdy_in is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wbe_q   <= 1'b0;
            sig_q   <= 2'b00;
            rd_q    <= 5'd0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else if (bus.rdy_in) begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q <= ISSUE;
                        wbe_q   <= 1'b1;
                        sig_q   <= SCALAR_RF_WRITE;
                        rd_q    <= rd_mem[rptr_q];
                        data_q  <= data_mem[rptr_q];
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    wbe_q   <= 1'b0;
                    sig_q   <= 2'b00;
                end
                WAIT: begin
                    if (bus.rf_status == RF_FINISHED) begin
                        done_q <= 1'b1;
                        if (count_q > CW'(1)) begin
                            state_q <= ISSUE;
                            wbe_q   <= 1'b1;
                            sig_q   <= SCALAR_RF_WRITE;
                            rd_q    <= rd_mem[rptr_nx];
                            data_q  <= data_mem[rptr_nx];
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.write_back_enabled = wbe_q;
    assign bus.rf_signal          = sig_q;
    assign bus.rf_rd              = rd_q;
    assign bus.rf_data            = data_q;
    assign bus.wb_done            = done_q;
    assign bus.wb_busy            = (count_q != '0) | (state_q != IDLE);
endmodule

// File: tb/tb_scalar_write_back_unit.sv
// Scoreboard bench for the scalar write-back unit: directed cases
// followed by randomized traffic against a queue-based reference model.
module tb_scalar_write_back_unit;
    localparam int DEPTH = 4;
    localparam logic [1:0] RF_WRITE    = 2'b01;
    localparam logic [1:0] RF_FINISHED = 2'b01;
    localparam logic [1:0] RF_NOP      = 2'b00;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scalar_write_back_unit_if #(.DATA_LEN(32), .SCALAR_REG_LEN(64)) bus ();

    scalar_write_back_unit #(
        .DATA_LEN(32), .SCALAR_REG_LEN(64), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    wr_t  exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pushed   = 0;
    int   retired  = 0;
    logic waiting  = 1'b0;
    logic exp_done = 1'b0;
    logic rf_hold  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Load extension from arithmetic: keep the low bits, subtract 2^bits
    // when the value is negative in two's complement.
    function automatic logic [63:0] ext_model(input logic [31:0] raw,
                                              input logic [1:0] sz,
                                              input logic uns);
        int     bits;
        longint v;
        bits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
        v = longint'({32'd0, raw}) & ((longint'(1) << bits) - 1);
        if (!uns && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return 64'(v);
    endfunction

    // Register-file model: random completion unless held off.
    initial begin
        bus.rf_status = RF_NOP;
        forever begin
            @(posedge clk);
            #1;
            bus.rf_status = rf_hold ? RF_NOP :
                            (($urandom % 3) != 0) ? RF_FINISHED : RF_NOP;
        end
    end

    // Monitor: pops expected writes as the DUT issues them.
    initial begin
        wr_t  e;
        logic popn;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                retired  = 0;
                waiting  = 1'b0;
                exp_done = 1'b0;
            end else begin
                chk("wb_done", {63'd0, bus.wb_done}, {63'd0, exp_done});
                if (bus.rdy_in) begin
                    popn = 1'b0;
                    if (bus.write_back_enabled) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_write: got rd=%0d data=%0h expected none",
                                     bus.rf_rd, bus.rf_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wr_rd", {59'd0, bus.rf_rd}, {59'd0, e.rd});
                            chk("wr_data", bus.rf_data, e.data);
                            chk("rf_signal", {62'd0, bus.rf_signal}, {62'd0, RF_WRITE});
                        end
                        waiting = 1'b1;
                    end else if (waiting && bus.rf_status == RF_FINISHED) begin
                        retired++;
                        waiting = 1'b0;
                        popn    = 1'b1;
                    end
                    exp_done = popn;
                end
            end
        end
    end

    // One stimulus cycle: drive, check readies against the model occupancy,
    // and record the writes the accepted results must produce.
    task automatic drive(input logic rdy,
                         input logic av, input logic [4:0] ard,
                         input logic [63:0] ad,
                         input logic mv, input logic [4:0] mrd,
                         input logic [31:0] md, input logic [1:0] ms,
                         input logic mu,
                         output logic ar, output logic mr);
        int occ;
        @(posedge clk);
        #1;
        bus.rdy_in       = rdy;
        bus.alu_valid    = av;
        bus.alu_rd       = ard;
        bus.alu_data     = ad;
        bus.mem_valid    = mv;
        bus.mem_rd       = mrd;
        bus.mem_data     = md;
        bus.mem_size     = ms;
        bus.mem_unsigned = mu;
        #3;
        ar  = bus.alu_ready;
        mr  = bus.mem_ready;
        occ = pushed - retired;
        if (rdy) begin
            chk("mem_ready", {63'd0, mr}, {63'd0, occ < DEPTH});
            chk("alu_ready", {63'd0, ar},
                {63'd0, (DEPTH - occ >= 2) || (DEPTH - occ >= 1 && !mv)});
        end else begin
            chk("mem_ready_frozen", {63'd0, mr}, 64'd0);
            chk("alu_ready_frozen", {63'd0, ar}, 64'd0);
        end
        if (mv && mr && mrd != 5'd0) begin
            exp_q.push_back('{rd: mrd, data: ext_model(md, ms, mu)});
            pushed++;
        end
        if (av && ar && ard != 5'd0) begin
            exp_q.push_back('{rd: ard, data: ad});
            pushed++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.alu_valid = 1'b0;
            bus.mem_valid = 1'b0;
            bus.rdy_in    = 1'b1;
            @(negedge clk);
        end
    endtask

    // Waits for the next issued write and compares it with literal values.
    task automatic wait_wbe(input string name, input logic [4:0] rd,
                            input logic [63:0] data, output int cyc);
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            bus.alu_valid = 1'b0;
            bus.mem_valid = 1'b0;
            @(negedge clk);
            if (bus.write_back_enabled) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no write expected rd=%0d", name, rd);
        end else begin
            chk({name, "_rd"}, {59'd0, bus.rf_rd}, {59'd0, rd});
            chk({name, "_data"}, bus.rf_data, data);
        end
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            idle(1);
            if (!bus.wb_busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got busy=%0d pending=%0d expected idle",
                     bus.wb_busy, exp_q.size());
        end
    endtask

    initial begin
        logic ar, mr, got;
        int   cyc;
        bus.rdy_in       = 1'b1;
        bus.alu_valid    = 1'b0;
        bus.alu_rd       = 5'd0;
        bus.alu_data     = 64'd0;
        bus.mem_valid    = 1'b0;
        bus.mem_rd       = 5'd0;
        bus.mem_data     = 32'd0;
        bus.mem_size     = 2'b00;
        bus.mem_unsigned = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wbe", {63'd0, bus.write_back_enabled}, 64'd0);
        chk("rst_sig", {62'd0, bus.rf_signal}, 64'd0);
        chk("rst_rd", {59'd0, bus.rf_rd}, 64'd0);
        chk("rst_data", bus.rf_data, 64'd0);
        chk("rst_busy", {63'd0, bus.wb_busy}, 64'd0);
        chk("rst_done", {63'd0, bus.wb_done}, 64'd0);

        // Single ALU write, issue one cycle after the push edge.
        drive(1, 1, 5'd5, 64'h1234, 0, 5'd0, 32'd0, 2'b00, 0, ar, mr);
        wait_wbe("t1", 5'd5, 64'h1234, cyc);
        chk("t1_latency", 64'(cyc), 64'd1);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.wb_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("t1_done_pulse", {63'd0, got}, 64'd1);
        drain();

        // Load extension.
        drive(1, 0, 5'd0, 64'd0, 1, 5'd6, 32'h0000_0080, 2'b00, 0, ar, mr);
        wait_wbe("t2_sb", 5'd6, 64'hFFFF_FFFF_FFFF_FF80, cyc);
        drain();
        drive(1, 0, 5'd0, 64'd0, 1, 5'd6, 32'h0000_0080, 2'b00, 1, ar, mr);
        wait_wbe("t2_ub", 5'd6, 64'h80, cyc);
        drain();
        drive(1, 0, 5'd0, 64'd0, 1, 5'd7, 32'h8000_0000, 2'b10, 0, ar, mr);
        wait_wbe("t2_sw", 5'd7, 64'hFFFF_FFFF_8000_0000, cyc);
        drain();
        drive(1, 0, 5'd0, 64'd0, 1, 5'd8, 32'h0000_8001, 2'b01, 0, ar, mr);
        wait_wbe("t2_sh", 5'd8, 64'hFFFF_FFFF_FFFF_8001, cyc);
        drain();

        // Same-cycle load and ALU to the same register.
        drive(1, 1, 5'd3, 64'd2, 1, 5'd3, 32'd1, 2'b10, 0, ar, mr);
        chk("t3_alu_ready", {63'd0, ar}, 64'd1);
        chk("t3_mem_ready", {63'd0, mr}, 64'd1);
        wait_wbe("t3_first", 5'd3, 64'd1, cyc);
        wait_wbe("t3_second", 5'd3, 64'd2, cyc);
        drain();

        // Fill while the register file stalls, then release.
        rf_hold = 1'b1;
        for (int i = 0; i < 4; i++)
            drive(1, 1, 5'(10 + i), 64'(100 + i), 0, 5'd0, 32'd0, 2'b00, 0, ar, mr);
        drive(1, 1, 5'd14, 64'd200, 1, 5'd15, 32'd9, 2'b10, 0, ar, mr);
        chk("t4_full_alu", {63'd0, ar}, 64'd0);
        chk("t4_full_mem", {63'd0, mr}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t4_rd_stable", {59'd0, bus.rf_rd}, 64'd10);
        end
        rf_hold = 1'b0;
        drain();

        // x0 destination is accepted and dropped.
        drive(1, 1, 5'd0, 64'd7, 0, 5'd0, 32'd0, 2'b00, 0, ar, mr);
        chk("t5_alu_ready", {63'd0, ar}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("t5_no_wbe", {63'd0, bus.write_back_enabled}, 64'd0);
            chk("t5_not_busy", {63'd0, bus.wb_busy}, 64'd0);
        end

        // Randomized traffic with rdy_in stalls.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 8) != 0,
                  ($urandom % 2) != 0, 5'($urandom % 6 == 0 ? 0 : $urandom),
                  {$urandom, $urandom},
                  ($urandom % 2) != 0, 5'($urandom % 6 == 0 ? 0 : $urandom),
                  $urandom, 2'($urandom), 1'($urandom),
                  ar, mr);
        end
        drain();
        chk("rand_all_retired", 64'(retired), 64'(pushed));

        // Reset while a write waits with another queued behind it.
        rf_hold = 1'b1;
        drive(1, 1, 5'd21, 64'h55, 1, 5'd20, 32'h44, 2'b10, 1, ar, mr);
        idle(5);
        chk("t6_pre_busy", {63'd0, bus.wb_busy}, 64'd1);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        pushed = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_wbe", {63'd0, bus.write_back_enabled}, 64'd0);
        chk("t6_sig", {62'd0, bus.rf_signal}, 64'd0);
        chk("t6_rd", {59'd0, bus.rf_rd}, 64'd0);
        chk("t6_data", bus.rf_data, 64'd0);
        chk("t6_done", {63'd0, bus.wb_done}, 64'd0);
        chk("t6_busy", {63'd0, bus.wb_busy}, 64'd0);
        rf_hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            chk("t6_no_write", {63'd0, bus.write_back_enabled}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end
endmodule
